// File: rtl/timer_pkg.sv
// Shared types and helpers for the hold-timer bank.
package timer_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL  = 2'd0,
        MODE_PULSE  = 2'd1,
        MODE_STICKY = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    // Channel-select width; a single channel still needs a 1-bit select.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/timer_chan.sv
// One hold timer: saturating counter, threshold compare, level/pulse/sticky output.
// Latency: output reflects the counter one cycle after each sampled input.
// Backpressure: none; free-running every cycle.
module timer_chan
    import timer_pkg::*;
#(
    parameter int               CNT_W     = 13,
    parameter logic [CNT_W-1:0] THR_INIT  = '0,
    parameter logic [1:0]       MODE_INIT = 2'd0
) (
    input  logic             S_AXIS_ACLK,
    input  logic             S_AXIS_ARESET,
    input  logic             ti,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_thr,
    input  logic [1:0]       cfg_mode,
    input  logic             clr,
    output logic             to,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] thr_e;
    mode_t            mode;
    logic             reached;
    logic             reached_q;
    logic             latch;

    // A zero threshold behaves as one so the output can never be high at cnt 0.
    assign thr_e   = (thr == '0) ? CNT_W'(1) : thr;
    assign reached = (cnt >= thr_e);

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            cnt       <= '0;
            thr       <= THR_INIT;
            mode      <= mode_t'(MODE_INIT);
            reached_q <= 1'b0;
            latch     <= 1'b0;
        end else begin
            if (!ti) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (cfg_we) begin
                thr       <= cfg_thr;
                mode      <= mode_t'(cfg_mode);
                reached_q <= 1'b0;
                latch     <= 1'b0;
            end else begin
                reached_q <= reached;
                // Set beats clear when both happen in the same cycle.
                if (mode == MODE_STICKY && reached) begin
                    latch <= 1'b1;
                end else if (clr) begin
                    latch <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        to = reached;
        case (mode)
            MODE_PULSE:  to = reached & ~reached_q;
            MODE_STICKY: to = latch | reached;
            default:     to = reached;
        endcase
    end

endmodule

// File: rtl/timer_array.sv
// Bank of NUM_CH hold timers with per-channel config writes and counter readback.
// Latency: to follows each channel one cycle after sampling; rd_cnt is registered (1 cycle).
// Backpressure: none; config writes are single-cycle strobes, out-of-range channels dropped.
module timer_array
    import timer_pkg::*;
#(
    parameter int                      NUM_CH    = 5,
    parameter int                      CNT_W     = 13,
    parameter logic [NUM_CH*CNT_W-1:0] THR_INIT  = {13'd1085, 13'd34, 13'd1, 13'd31, 13'd34},
    parameter logic [NUM_CH*2-1:0]     MODE_INIT = '0,
    localparam int                     CH_W      = ch_w(NUM_CH)
) (
    input  logic              S_AXIS_ACLK,
    input  logic              S_AXIS_ARESET,
    input  logic [NUM_CH-1:0] ti,
    output logic [NUM_CH-1:0] to,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_thr,
    input  logic [1:0]        cfg_mode,
    input  logic [NUM_CH-1:0] clr,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [CNT_W-1:0]  rd_cnt
);

    logic [CNT_W-1:0] cnt_arr [NUM_CH];
    logic [CNT_W-1:0] rd_mux;

    // Only channels 0..NUM_CH-1 can match, so out-of-range writes fall through.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_chan #(
            .CNT_W     (CNT_W),
            .THR_INIT  (THR_INIT[i*CNT_W +: CNT_W]),
            .MODE_INIT (MODE_INIT[i*2 +: 2])
        ) u_chan (
            .S_AXIS_ACLK   (S_AXIS_ACLK),
            .S_AXIS_ARESET (S_AXIS_ARESET),
            .ti            (ti[i]),
            .cfg_we        (cfg_we && (cfg_ch == CH_W'(i))),
            .cfg_thr       (cfg_thr),
            .cfg_mode      (cfg_mode),
            .clr           (clr[i]),
            .to            (to[i]),
            .cnt           (cnt_arr[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_mux = cnt_arr[i];
            end
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            rd_cnt <= '0;
        end else begin
            rd_cnt <= rd_mux;
        end
    end

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array: default 5-channel bank plus a 1-channel 4-bit bank for saturation.
module tb_timer_array;

    logic        S_AXIS_ACLK;
    logic        S_AXIS_ARESET;
    logic [4:0]  ti;
    logic [4:0]  to;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [12:0] cfg_thr;
    logic [1:0]  cfg_mode;
    logic [4:0]  clr;
    logic [2:0]  rd_ch;
    logic [12:0] rd_cnt;

    logic [0:0]  ti2;
    logic [0:0]  to2;
    logic        cfg_we2;
    logic [0:0]  cfg_ch2;
    logic [3:0]  cfg_thr2;
    logic [1:0]  cfg_mode2;
    logic [0:0]  clr2;
    logic [0:0]  rd_ch2;
    logic [3:0]  rd_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    timer_array dut (
        .S_AXIS_ACLK   (S_AXIS_ACLK),
        .S_AXIS_ARESET (S_AXIS_ARESET),
        .ti            (ti),
        .to            (to),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_thr       (cfg_thr),
        .cfg_mode      (cfg_mode),
        .clr           (clr),
        .rd_ch         (rd_ch),
        .rd_cnt        (rd_cnt)
    );

    timer_array #(
        .NUM_CH    (1),
        .CNT_W     (4),
        .THR_INIT  (4'd15),
        .MODE_INIT (2'd0)
    ) dut_sat (
        .S_AXIS_ACLK   (S_AXIS_ACLK),
        .S_AXIS_ARESET (S_AXIS_ARESET),
        .ti            (ti2),
        .to            (to2),
        .cfg_we        (cfg_we2),
        .cfg_ch        (cfg_ch2),
        .cfg_thr       (cfg_thr2),
        .cfg_mode      (cfg_mode2),
        .clr           (clr2),
        .rd_ch         (rd_ch2),
        .rd_cnt        (rd_cnt2)
    );

    initial S_AXIS_ACLK = 1'b0;
    always #5 S_AXIS_ACLK = ~S_AXIS_ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change then too.
    task automatic tick();
        @(posedge S_AXIS_ACLK);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [12:0] thr, input logic [1:0] mode);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_thr  = thr;
        cfg_mode = mode;
        tick();
        cfg_we   = 1'b0;
    endtask

    initial begin
        int pulses;
        int first_at;
        int drops;

        S_AXIS_ARESET = 1'b1;
        ti = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_thr = '0; cfg_mode = '0;
        clr = '0; rd_ch = '0;
        ti2 = '0; cfg_we2 = 1'b0; cfg_ch2 = '0; cfg_thr2 = '0; cfg_mode2 = '0;
        clr2 = '0; rd_ch2 = '0;
        repeat (3) tick();
        S_AXIS_ARESET = 1'b0;
        chk("reset_to", 32'(to), 32'd0);
        chk("reset_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("reset_to_sat", 32'(to2), 32'd0);

        // Level mode, ch0 threshold 34
        ti[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 33) chk("lvl_before_thr", 32'(to[0]), 32'd0);
            if (k == 34) chk("lvl_at_thr", 32'(to[0]), 32'd1);
            if (k == 40) chk("lvl_hold", 32'(to[0]), 32'd1);
        end
        ti[0] = 1'b0;
        tick();
        chk("lvl_fall", 32'(to[0]), 32'd0);
        chk("rd_cnt_ch0", 32'(rd_cnt), 32'd40);

        // Threshold 0 behaves as 1 on ch2
        cfg_write(3'd2, 13'd0, 2'd0);
        chk("thr0_idle", 32'(to[2]), 32'd0);
        ti[2] = 1'b1;
        tick();
        chk("thr0_first", 32'(to[2]), 32'd1);
        ti[2] = 1'b0;
        tick();
        chk("thr0_fall", 32'(to[2]), 32'd0);
        cfg_write(3'd2, 13'd1, 2'd0);
        ti[2] = 1'b1;
        tick();
        chk("thr1_first", 32'(to[2]), 32'd1);
        ti[2] = 1'b0;
        tick();
        chk("thr1_fall", 32'(to[2]), 32'd0);

        // Pulse mode, ch1 threshold 31
        cfg_write(3'd1, 13'd31, 2'd1);
        for (int ep = 0; ep < 2; ep++) begin
            pulses = 0;
            first_at = 0;
            ti[1] = 1'b1;
            for (int k = 1; k <= 100; k++) begin
                tick();
                if (to[1]) begin
                    pulses++;
                    if (first_at == 0) first_at = k;
                end
            end
            ti[1] = 1'b0;
            tick();
            chk(ep == 0 ? "pulse1_count" : "pulse2_count", 32'(pulses), 32'd1);
            chk(ep == 0 ? "pulse1_at" : "pulse2_at", 32'(first_at), 32'd31);
        end

        // Sticky mode, ch3 threshold 34
        cfg_write(3'd3, 13'd34, 2'd2);
        ti[3] = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (k == 33) chk("sticky_before", 32'(to[3]), 32'd0);
            if (k == 34) chk("sticky_at", 32'(to[3]), 32'd1);
        end
        ti[3] = 1'b0;
        repeat (5) tick();
        chk("sticky_held", 32'(to[3]), 32'd1);
        clr[3] = 1'b1;
        tick();
        clr[3] = 1'b0;
        chk("sticky_clr", 32'(to[3]), 32'd0);
        ti[3] = 1'b1;
        repeat (34) tick();
        chk("sticky_again", 32'(to[3]), 32'd1);
        clr[3] = 1'b1;
        ti[3]  = 1'b0;
        tick();
        chk("sticky_set_wins", 32'(to[3]), 32'd1);
        tick();
        clr[3] = 1'b0;
        chk("sticky_clr2", 32'(to[3]), 32'd0);

        // Out-of-range write must not touch any channel
        cfg_write(3'd7, 13'd1, 2'd0);
        ti = 5'b00011;
        repeat (3) tick();
        chk("cfg_ch7_ignored", 32'(to), 32'd0);
        ti = '0;
        tick();

        // Ch4 to cnt 500, lower threshold, then reset mid-count
        rd_ch = 3'd4;
        ti[4] = 1'b1;
        repeat (500) tick();
        chk("ch4_not_yet", 32'(to[4]), 32'd0);
        chk("rd_cnt_ch4", 32'(rd_cnt), 32'd499);
        cfg_write(3'd4, 13'd10, 2'd0);
        chk("ch4_lowered", 32'(to[4]), 32'd1);
        S_AXIS_ARESET = 1'b1;
        cfg_we   = 1'b1;
        cfg_ch   = 3'd0;
        cfg_thr  = 13'd1;
        cfg_mode = 2'd0;
        tick();
        S_AXIS_ARESET = 1'b0;
        cfg_we = 1'b0;
        chk("rst_mid_to", 32'(to), 32'd0);
        chk("rst_mid_rd", 32'(rd_cnt), 32'd0);
        ti = 5'b10011;
        for (int k = 1; k <= 1085; k++) begin
            tick();
            if (k == 1)    chk("rst_thr0_restored", 32'(to[0]), 32'd0);
            if (k == 34)   chk("rst_ch0_at", 32'(to[0]), 32'd1);
            if (k == 32)   chk("rst_mode1_level", 32'(to[1]), 32'd1);
            if (k == 1084) chk("rst_ch4_before", 32'(to[4]), 32'd0);
            if (k == 1085) chk("rst_ch4_at", 32'(to[4]), 32'd1);
        end
        ti = '0;
        tick();

        // Saturation on the 4-bit bank
        drops = 0;
        ti2 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 14) chk("sat_before", 32'(to2), 32'd0);
            if (k >= 15 && !to2[0]) drops++;
        end
        chk("sat_level_drops", 32'(drops), 32'd0);
        chk("sat_rd_cnt", 32'(rd_cnt2), 32'd15);
        ti2 = 1'b0;
        tick();
        chk("sat_fall", 32'(to2), 32'd0);
        cfg_we2   = 1'b1;
        cfg_thr2  = 4'd15;
        cfg_mode2 = 2'd1;
        tick();
        cfg_we2 = 1'b0;
        pulses = 0;
        ti2 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (to2[0]) pulses++;
        end
        chk("sat_pulse_once", 32'(pulses), 32'd1);
        ti2 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
